matrix_frame_loader: RTL and testbench

MATRIX_FRAME_LOADER -- requirements
Module: matrix_frame_loader

---
 rtl/matrix_frame_loader.sv | 111 +++++++++++
 tb/tb_matrix_frame_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_loader.sv
// matrix_frame_loader
//   Double-buffered frame loader for an 8x8 LED matrix scan stage.
//   Row bytes are written into a shadow buffer through a valid/ready port.
//   A beat marked WR_LAST requests that the shadow buffer be shown. The
//   displayed frame (DAT_O) is only replaced at a frame boundary, so a scan
//   of 8 columns never shows a torn image.
//
// Parameters
//   CLK_REF  : reference clock frequency in Hz
//   CLK_CE   : column-scan enable rate in Hz (DIV = CLK_REF/CLK_CE, >= 2)
//
// Ports
//   CLK      : system clock, rising edge
//   RST      : asynchronous active-high reset
//   WR_VALID : write beat offered
//   WR_READY : loader accepts a beat this cycle (low while a swap is pending)
//   WR_ROW   : target row of the beat
//   WR_DATA  : pixel byte for that row
//   WR_LAST  : beat closes the frame and requests display
//   CE_O     : one-cycle column-scan enable pulse, period DIV
//   DAT_O    : displayed frame, row r on bits [8r+7:8r]
//   COL_IDX  : current scan column, advances on each CE_O
//   SWAP_O   : one-cycle pulse in the cycle after DAT_O took a new frame

module matrix_frame_loader #(
  parameter int CLK_REF = 48_000_000,
  parameter int CLK_CE  = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [2:0]  WR_ROW,
  input  logic [7:0]  WR_DATA,
  input  logic        WR_LAST,
  output logic        CE_O,
  output logic [63:0] DAT_O,
  output logic [2:0]  COL_IDX,
  output logic        SWAP_O
);

  localparam int DIV = CLK_REF / CLK_CE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } state_t;

  logic [CW-1:0] pre_cnt;
  logic [63:0]   shadow;
  state_t        state;
  logic          accept;
  logic          boundary;

  // The scan enable is decoded straight from the prescaler so it is high for
  // exactly the one cycle where the count sits at DIV-1. Since the count is
  // 0 in reset and DIV >= 2, CE_O is low in reset without extra gating.
  assign CE_O     = (pre_cnt == CNT_MAX);
  assign boundary = CE_O && (COL_IDX == 3'd7);
  assign WR_READY = (state != PENDING);
  assign accept   = WR_VALID && WR_READY;

  // Free-running prescaler, 0..DIV-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt <= '0;
    end else if (pre_cnt == CNT_MAX) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Column counter mirrors the display's own column counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COL_IDX <= 3'd0;
    end else if (CE_O) begin
      COL_IDX <= COL_IDX + 3'd1;
    end
  end

  // Write FSM, shadow buffer and displayed frame. While PENDING no beat can
  // be accepted, so the swap and a shadow write never collide. A WR_LAST beat
  // landing on a boundary edge sees the old state (not PENDING), so it waits
  // for the following boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      shadow <= 64'h0;
      DAT_O  <= 64'h0;
      SWAP_O <= 1'b0;
    end else begin
      SWAP_O <= 1'b0;
      if (state == PENDING) begin
        if (boundary) begin
          DAT_O  <= shadow;
          SWAP_O <= 1'b1;
          state  <= IDLE;
        end
      end else if (accept) begin
        shadow[{WR_ROW, 3'b000} +: 8] <= WR_DATA;
        state <= WR_LAST ? PENDING : LOAD;
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// tb_matrix_frame_loader
//   Directed bench for matrix_frame_loader. A DIV=4 instance carries the
//   functional tests; a default-parameter instance (DIV=48) is used for the
//   scan-enable period check. Inputs change and outputs are sampled 1 time
//   unit after each rising edge.

module tb_matrix_frame_loader;

  logic        CLK;
  logic        RST;
  logic        WR_VALID;
  logic        WR_READY;
  logic [2:0]  WR_ROW;
  logic [7:0]  WR_DATA;
  logic        WR_LAST;
  logic        CE_O;
  logic [63:0] DAT_O;
  logic [2:0]  COL_IDX;
  logic        SWAP_O;

  logic        ready48;
  logic        ce48;
  logic [63:0] dat48;
  logic [2:0]  col48;
  logic        swap48;

  int checks;
  int errors;

  matrix_frame_loader #(
    .CLK_REF(48_000_000),
    .CLK_CE (12_000_000)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .WR_VALID(WR_VALID),
    .WR_READY(WR_READY),
    .WR_ROW  (WR_ROW),
    .WR_DATA (WR_DATA),
    .WR_LAST (WR_LAST),
    .CE_O    (CE_O),
    .DAT_O   (DAT_O),
    .COL_IDX (COL_IDX),
    .SWAP_O  (SWAP_O)
  );

  matrix_frame_loader dut48 (
    .CLK     (CLK),
    .RST     (RST),
    .WR_VALID(1'b0),
    .WR_READY(ready48),
    .WR_ROW  (3'd0),
    .WR_DATA (8'd0),
    .WR_LAST (1'b0),
    .CE_O    (ce48),
    .DAT_O   (dat48),
    .COL_IDX (col48),
    .SWAP_O  (swap48)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge CLK);
    #1;
  endtask

  // Offer one beat for one edge; WR_READY is expected high so it is accepted.
  task automatic applyStimulus(input logic [2:0] row, input logic [7:0] data, input logic last);
    WR_VALID = 1'b1;
    WR_ROW   = row;
    WR_DATA  = data;
    WR_LAST  = last;
    stepClk();
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
  endtask

  // Step until SWAP_O is seen (bounded), counting edges and any DAT_O change
  // that is not accompanied by a swap pulse.
  task automatic waitSwap(input int budget, output int cycles, output bit seen, output int tears);
    logic [63:0] prev;
    seen   = 1'b0;
    cycles = 0;
    tears  = 0;
    prev   = DAT_O;
    for (int i = 1; i <= budget; i++) begin
      stepClk();
      cycles = i;
      if (SWAP_O) begin
        seen = 1'b1;
        break;
      end
      if (DAT_O !== prev) tears++;
    end
  endtask

  int  cyc;
  bit  seen;
  int  tears;
  int  swapCount;
  int  badCe;
  int  badCol;
  int  datChange;
  int  period;
  bit  found;

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b1;
    WR_VALID = 1'b0;
    WR_ROW   = 3'd0;
    WR_DATA  = 8'd0;
    WR_LAST  = 1'b0;

    // Reset state.
    repeat (3) stepClk();
    checkOutput("rst_ce",    {63'd0, CE_O},     64'd0);
    checkOutput("rst_col",   {61'd0, COL_IDX},  64'd0);
    checkOutput("rst_dat",   DAT_O,             64'd0);
    checkOutput("rst_swap",  {63'd0, SWAP_O},   64'd0);
    checkOutput("rst_ready", {63'd0, WR_READY}, 64'd1);

    // Idle scan: after edge k, CE_O = (k%4==3), COL_IDX = (k/4)%8.
    RST = 1'b0;
    badCe = 0; badCol = 0; swapCount = 0; datChange = 0;
    for (int k = 1; k <= 36; k++) begin
      stepClk();
      if (CE_O !== ((k % 4) == 3)) badCe++;
      if (COL_IDX !== 3'((k / 4) % 8)) badCol++;
      if (SWAP_O) swapCount++;
      if (DAT_O !== 64'd0) datChange++;
      if (k == 3) checkOutput("first_ce", {63'd0, CE_O}, 64'd1);
      if (k == 2) checkOutput("no_early_ce", {63'd0, CE_O}, 64'd0);
      if (k == 32) checkOutput("col_wrap", {61'd0, COL_IDX}, 64'd0);
    end
    checkOutput("idle_ce_pattern",  64'(badCe),     64'd0);
    checkOutput("idle_col_pattern", 64'(badCol),    64'd0);
    checkOutput("idle_no_swap",     64'(swapCount), 64'd0);
    checkOutput("idle_dat_zero",    64'(datChange), 64'd0);

    // Full frame, rows 0..7 = 01,02,...,80, last on row 7.
    checkOutput("ready_before_load", {63'd0, WR_READY}, 64'd1);
    for (int r = 0; r < 8; r++) begin
      applyStimulus(3'(r), 8'(1 << r), r == 7);
    end
    checkOutput("ready_pending", {63'd0, WR_READY}, 64'd0);
    checkOutput("dat_before_swap", DAT_O, 64'd0);
    waitSwap(40, cyc, seen, tears);
    checkOutput("swap1_seen", {63'd0, seen}, 64'd1);
    checkOutput("swap1_dat", DAT_O, 64'h8040201008040201);
    checkOutput("swap1_col", {61'd0, COL_IDX}, 64'd0);
    checkOutput("swap1_no_tear", 64'(tears), 64'd0);
    checkOutput("swap1_ready", {63'd0, WR_READY}, 64'd1);
    stepClk();
    checkOutput("swap1_one_pulse", {63'd0, SWAP_O}, 64'd0);

    // Partial frame: row 3 = FF with last; then keep offering row 0 = AA
    // during PENDING, which must not be written.
    applyStimulus(3'd3, 8'hFF, 1'b1);
    WR_VALID = 1'b1;
    WR_ROW   = 3'd0;
    WR_DATA  = 8'hAA;
    WR_LAST  = 1'b0;
    waitSwap(40, cyc, seen, tears);
    WR_VALID = 1'b0;
    checkOutput("swap2_seen", {63'd0, seen}, 64'd1);
    checkOutput("swap2_dat", DAT_O, 64'h80402010FF040201);
    checkOutput("swap2_no_tear", 64'(tears), 64'd0);

    // WR_LAST beat on the exact boundary edge: swap comes one scan later.
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (CE_O && COL_IDX == 3'd7) begin
        found = 1'b1;
        break;
      end
      stepClk();
    end
    checkOutput("boundary_found", {63'd0, found}, 64'd1);
    applyStimulus(3'd5, 8'h55, 1'b1);
    checkOutput("bnd_no_swap", {63'd0, SWAP_O}, 64'd0);
    checkOutput("bnd_ready_low", {63'd0, WR_READY}, 64'd0);
    checkOutput("bnd_dat_hold", DAT_O, 64'h80402010FF040201);
    waitSwap(64, cyc, seen, tears);
    checkOutput("swap3_seen", {63'd0, seen}, 64'd1);
    checkOutput("swap3_latency", 64'(cyc), 64'd32);
    checkOutput("swap3_dat", DAT_O, 64'h80405510FF040201);

    // Reset while PENDING discards the shadow and the pending swap.
    stepClk();
    applyStimulus(3'd1, 8'hEE, 1'b1);
    checkOutput("pend_before_rst", {63'd0, WR_READY}, 64'd0);
    #3 RST = 1'b1;
    #1;
    checkOutput("arst_dat",   DAT_O,             64'd0);
    checkOutput("arst_ready", {63'd0, WR_READY}, 64'd1);
    checkOutput("arst_col",   {61'd0, COL_IDX},  64'd0);
    checkOutput("arst_ce",    {63'd0, CE_O},     64'd0);
    checkOutput("arst_swap",  {63'd0, SWAP_O},   64'd0);
    stepClk();
    RST = 1'b0;
    swapCount = 0;
    datChange = 0;
    for (int k = 0; k < 40; k++) begin
      stepClk();
      if (SWAP_O) swapCount++;
      if (DAT_O !== 64'd0) datChange++;
    end
    checkOutput("post_rst_no_swap", 64'(swapCount), 64'd0);
    checkOutput("post_rst_dat",     64'(datChange), 64'd0);

    // Default build: CE_O period 48.
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ce48) begin
        found = 1'b1;
        break;
      end
      stepClk();
    end
    checkOutput("ce48_found", {63'd0, found}, 64'd1);
    period = 0;
    for (int i = 1; i <= 100; i++) begin
      stepClk();
      if (ce48) begin
        period = i;
        break;
      end
    end
    checkOutput("ce48_period", 64'(period), 64'd48);
    checkOutput("dut48_dat", dat48, 64'd0);
    checkOutput("dut48_swap", {63'd0, swap48}, 64'd0);
    checkOutput("dut48_ready", {63'd0, ready48}, 64'd1);
    checkOutput("dut48_col_range", {63'd0, (col48 <= 3'd7)}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
